ram_access_arbiter: RTL and testbench
=====================================

// Module: ram_access_arbiter
// PURPOSE
//  Sequencer and arbiter for the data RAM. Shares one single-port, word-wide, byte-writable RAM (1-cycle read latency) between
//  two requesters: m0 = CPU load/store unit, m1 = debug/loader port.
//  Generates byte enables and lane-shifted store data, splits word-crossing accesses into two RAM beats, and returns
//  read data right-aligned and zero-extended. The existing read-extension logic then applies sign extension with lowerAddr=0.
// PARAMETERS
//  ADDR_W  16  byte-address width; RAM word address is ADDR_W-2 bits
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  mX_req_valid in   1       request valid (X = 0,1; same set per requester)
//  mX_req_ready out  1       request accepted this cycle when valid&&ready
//  mX_req_we    in   1       1 = store, 0 = load
//  mX_req_size  in   2       00 byte, 01 half, 10/11 word
//  mX_req_addr  in   ADDR_W  byte address, any alignment
//  mX_req_wdata in   32      store data, right-aligned
//  mX_rsp_valid out  1       one-cycle completion pulse (loads and stores)
//  rsp_rdata    out  32      load result, valid with mX_rsp_valid; shared by both ports
//  ram_en       out  1       RAM access strobe
//  ram_we       out  4       byte write enables (0 = read)
//  ram_addr     out  ADDR_W-2  RAM word address
//  ram_wdata    out  32      RAM write data, lane-positioned
//  ram_rdata    in   32      RAM read data, valid the cycle after ram_en
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0; rr_last=1, so m0 wins first; all internal registers cleared.
//  - Reset mid-operation: the access is abandoned and no rsp pulse is issued. A split store may leave only beat0 written.
//  - FSM: IDLE -> ACC0 -> [ACC1 if split] -> WAIT -> RESP -> IDLE.
//  - IDLE: mX_req_ready = grant to X (combinational). On valid&&ready, latch we/size/addr/wdata/port; go to ACC0.
//  - Arbitration: one valid port wins. If both are valid, the port != rr_last wins. rr_last updates on every accept.
//  - ready is 0 in all states except IDLE. No back-to-back accept: one access in flight at a time.
//  - off = addr[1:0]; bytes n = 1/2/4; mask = (1<<n)-1; split = off+n > 4.
//  - ACC0: ram_en=1, ram_addr=addr[ADDR_W-1:2], ram_we = store ? (mask<<off)[3:0] : 0, ram_wdata = wdata<<(8*off).
//  - ACC1: ram_en=1, ram_addr = word+1 (wraps modulo 2^(ADDR_W-2)), ram_we = store ? mask>>(4-off) : 0, ram_wdata = wdata>>(8*(4-off)).
//    Also captures beat0 ram_rdata.
//  - WAIT: captures the last beat's ram_rdata. ram_en=0.
//  - rdata = (b0>>(8*off)) | (split ? b1<<(8*(4-off)) : 0). Bytes above n are forced to 0.
//  - RESP: mX_rsp_valid=1 for the latched port only. rsp_rdata is registered and held until the next RESP; it is 0 for stores.
//  - Latency from accept edge T: ram_en at T+1 (and T+2 if split); rsp_valid at T+3 unsplit, T+4 split.
//  - The requester must sink rsp; there is no response back-pressure.
//  - Request inputs after accept are don't-care; latched copies are used.
//  - All ram_* outputs are 0 when ram_en=0.
// TESTING
//  1 word4=0xDEADBEEF; m0 load W @0x0010 accepted at T -> T+1 ram_en, addr 4, we 0; T+3 m0_rsp_valid, rsp_rdata 0xDEADBEEF.
//  2 m0 store B @0x0013 wdata 0x000000AB -> single beat: addr 4, we 4'b1000, wdata 0xAB000000; rsp at T+3.
//  3 word4=0x11223344, word5=0x55667788; load H @0x0013 -> beats addr 4 then 5, we 0;
//    rsp_rdata 0x00008811 at T+4.
//  4 store W @0x0006 wdata 0xA1B2C3D4 -> beat0 addr 1, we 1100, wdata 0xC3D40000;
//    beat1 addr 2, we 0011, wdata 0x0000A1B2.
//  5 after reset, m0 and m1 valid together -> m0 granted, m1_ready 0 until IDLE;
//    m1 granted next even if m0 re-requests; m0_rsp_valid never pulses for m1.
//  6 load W @0xFFFE -> beats addr 0x3FFF then 0x0000. Then assert rst_n=0 during ACC1 of a split store
//    -> outputs 0 immediately, no rsp; next request after release completes normally.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: arbitrates two requesters onto one single-port,
// byte-writable, word-wide RAM with 1-cycle read latency. Word-crossing
// accesses become two RAM beats; load data comes back right-aligned and
// zero-extended.
module ram_access_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (CPU load/store unit)
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [1:0]        m0_req_size,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [31:0]       m0_req_wdata,
  output logic              m0_rsp_valid,
  // requester 1 (debug/loader port)
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [1:0]        m1_req_size,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [31:0]       m1_req_wdata,
  output logic              m1_rsp_valid,
  // shared response data
  output logic [31:0]       rsp_rdata,
  // RAM side
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [ADDR_W-3:0] ONE_WORD = 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              port_q, port_d;
  logic              rr_last_q, rr_last_d;
  logic [31:0]       b0_q, b0_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  // Access geometry derived from the latched request
  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic [3:0]        mask;
  logic [2:0]        end_off;
  logic              split;
  logic [7:0]        we_lanes;
  logic [63:0]       wd_lanes;
  logic [31:0]       rd_lo, rd_hi;
  logic [63:0]       rd_lanes;
  logic [31:0]       byte_mask32;
  logic [31:0]       rdata_fmt;
  logic [ADDR_W-3:0] word_addr;
  logic              grant0, grant1;

  assign off       = addr_q[1:0];
  assign word_addr = addr_q[ADDR_W-1:2];
  assign nbytes    = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
  assign mask      = (size_q == 2'b00) ? 4'b0001 : (size_q == 2'b01) ? 4'b0011 : 4'b1111;
  assign end_off   = {1'b0, off} + nbytes;
  assign split     = end_off > 3'd4;

  // One 8-lane shift yields both beats: low half is beat0, high half beat1.
  assign we_lanes  = {4'b0000, mask} << off;
  assign wd_lanes  = {32'h0, wdata_q} << {off, 3'b000};

  // In WAIT the live RAM data is the last beat; beat0 sits in b0_q if split.
  assign rd_lo       = split ? b0_q : ram_rdata;
  assign rd_hi       = split ? ram_rdata : 32'h0;
  assign rd_lanes    = {rd_hi, rd_lo} >> {off, 3'b000};
  assign byte_mask32 = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign rdata_fmt   = rd_lanes[31:0] & byte_mask32;

  // Round-robin: on contention the port that did not win last time goes.
  assign grant0 = m0_req_valid && (!m1_req_valid || rr_last_q);
  assign grant1 = m1_req_valid && (!m0_req_valid || !rr_last_q);

  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rsp_rdata_q;

  // Next-state, register-load and output decode
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    port_d       = port_q;
    rr_last_d    = rr_last_q;
    b0_d         = b0_q;
    rsp_rdata_d  = rsp_rdata_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_addr     = '0;
    ram_wdata    = 32'h0;

    case (state_q)
      S_IDLE: begin
        // Ready is held low while reset is applied so all outputs read 0.
        m0_req_ready = grant0 & rst_n;
        m1_req_ready = grant1 & rst_n;
        if (grant0 || grant1) begin
          port_d    = grant1;
          rr_last_d = grant1;
          we_d      = grant1 ? m1_req_we    : m0_req_we;
          size_d    = grant1 ? m1_req_size  : m0_req_size;
          addr_d    = grant1 ? m1_req_addr  : m0_req_addr;
          wdata_d   = grant1 ? m1_req_wdata : m0_req_wdata;
          state_d   = S_ACC0;
        end
      end
      S_ACC0: begin
        ram_en    = 1'b1;
        ram_addr  = word_addr;
        ram_we    = we_q ? we_lanes[3:0] : 4'b0000;
        ram_wdata = we_q ? wd_lanes[31:0] : 32'h0;
        state_d   = split ? S_ACC1 : S_WAIT;
      end
      S_ACC1: begin
        ram_en    = 1'b1;
        ram_addr  = word_addr + ONE_WORD;
        ram_we    = we_q ? we_lanes[7:4] : 4'b0000;
        ram_wdata = we_q ? wd_lanes[63:32] : 32'h0;
        b0_d      = ram_rdata;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        rsp_rdata_d = we_q ? 32'h0 : rdata_fmt;
        state_d     = S_RESP;
      end
      S_RESP: begin
        m0_rsp_valid = !port_q;
        m1_rsp_valid = port_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      port_q      <= 1'b0;
      rr_last_q   <= 1'b1;
      b0_q        <= 32'h0;
      rsp_rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its _d input, independent of statement order.
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      port_q      <= port_d;
      rr_last_q   <= rr_last_d;
      b0_q        <= b0_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed and randomized checks of the RAM arbiter
// against a byte-addressed reference memory kept in the bench.
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [1:0]  m0_req_size;
  logic [15:0] m0_req_addr;
  logic [31:0] m0_req_wdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [1:0]  m1_req_size;
  logic [15:0] m1_req_addr;
  logic [31:0] m1_req_wdata;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        busy;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int cyc = 0;

  ram_access_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_size(m0_req_size), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_size(m1_req_size), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid),
    .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pre-existing RAM contents before any write
  function automatic logic [31:0] init_word(input logic [13:0] w);
    logic [31:0] x;
    x = {18'h0, w} * 32'h9E3779B1;
    return x ^ 32'h5A5A1234;
  endfunction

  // ---------------- RAM environment model (1-cycle read latency) ----------
  logic [31:0] ram_mem [16384];
  bit          ram_wr  [16384];
  logic        poke_en = 1'b0;
  logic [13:0] poke_w  = 14'h0;
  logic [31:0] poke_v  = 32'h0;

  function automatic logic [31:0] rd_word(input logic [13:0] w);
    return ram_wr[w] ? ram_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      ram_mem[poke_w] <= poke_v;
      ram_wr[poke_w]  <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= rd_word(ram_addr);
      if (ram_we != 4'b0000) begin
        ram_mem[ram_addr] <= merge(rd_word(ram_addr), ram_wdata, ram_we);
        ram_wr[ram_addr]  <= 1'b1;
      end
    end
  end

  // ---------------- Reference model: flat little-endian byte memory -------
  logic [7:0] ref_mem [65536];
  bit         ref_wr  [65536];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [15:0] a);
    logic [31:0] w;
    w = init_word(a[15:2]);
    return ref_wr[a] ? ref_mem[a] : w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] sz);
    logic [31:0] r;
    logic [15:0] ai;
    r = 32'h0;
    for (int i = 0; i < nbytes(sz); i++) begin
      ai = a + 16'(i);
      r[8*i +: 8] = ref_byte(ai);
    end
    return r;
  endfunction

  task automatic ref_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [15:0] ai;
    for (int i = 0; i < nbytes(sz); i++) begin
      ai = a + 16'(i);
      ref_mem[ai] = wd[8*i +: 8];
      ref_wr[ai]  = 1'b1;
    end
  endtask

  // ---------------- Bench utilities --------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input bit we, input logic [1:0] sz,
                       input logic [15:0] a, input logic [31:0] wd);
    if (!p) begin
      m0_req_valid = v; m0_req_we = we; m0_req_size = sz; m0_req_addr = a; m0_req_wdata = wd;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_size = sz; m1_req_addr = a; m1_req_wdata = wd;
    end
  endtask

  task automatic poke_word(input logic [13:0] w, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_w = w; poke_v = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ref_mem[{w, 2'(b)}] = v[8*b +: 8];
      ref_wr[{w, 2'(b)}]  = 1'b1;
    end
  endtask

  // Results of the most recent transaction
  logic [13:0] bt_addr  [4];
  logic [3:0]  bt_we    [4];
  logic [31:0] bt_wdata [4];
  int          bt_cyc   [4];
  int          nb;
  int          rsp_off;
  logic [31:0] rsp_data;

  // One complete request from port p, checked against the reference model
  task automatic xact(input bit p, input bit we, input logic [1:0] sz,
                      input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    logic [13:0] w1;
    bit          got;
    bit          sp;
    int          t_acc;
    sp  = (int'(a[1:0]) + nbytes(sz)) > 4;
    w1  = a[15:2] + 14'd1;
    exp = we ? 32'h0 : ref_load(a, sz);
    nb = 0; rsp_off = -1; rsp_data = 32'h0;
    @(negedge clk);
    drive(p, 1'b1, we, sz, a, wd);
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((p ? m1_req_ready : m0_req_ready) === 1'b1) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("accept", 64'(got), 64'(1));
    if (!got) begin
      drive(p, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
      return;
    end
    if (we) ref_store(a, sz, wd);
    @(posedge clk);
    #1;
    t_acc = cyc;
    drive(p, 1'b0, 1'($urandom), 2'($urandom), 16'($urandom), $urandom);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (ram_en) begin
        if (nb < 4) begin
          bt_addr[nb] = ram_addr; bt_we[nb] = ram_we; bt_wdata[nb] = ram_wdata;
          bt_cyc[nb] = cyc - t_acc;
        end
        nb++;
      end else begin
        check("ram_idle_zero", 64'({ram_we, ram_addr, ram_wdata}), 64'(0));
      end
      check("other_rsp_quiet", 64'(p ? m0_rsp_valid : m1_rsp_valid), 64'(0));
      if ((p ? m1_rsp_valid : m0_rsp_valid) === 1'b1) begin
        got = 1'b1; rsp_off = cyc - t_acc; rsp_data = rsp_rdata;
      end
    end
    check("rsp_seen", 64'(got), 64'(1));
    check("rsp_latency", 64'(rsp_off), 64'(sp ? 3 : 2));
    check("beat_count", 64'(nb), 64'(sp ? 2 : 1));
    check("beat0_addr", 64'(bt_addr[0]), 64'(a[15:2]));
    check("beat0_time", 64'(bt_cyc[0]), 64'(0));
    if (sp) check("beat1_addr", 64'(bt_addr[1]), 64'(w1));
    check("rsp_rdata", 64'(rsp_data), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0, n1;
    bit          done;
    logic [31:0] exp0, exp1;
    logic [15:0] ra;

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b10, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    #1;
    check("rst_outputs", 64'({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                              ram_en, ram_we, busy}), 64'(0));
    check("rst_ram_bus", 64'({ram_addr, ram_wdata}), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: aligned word load
    poke_word(14'd4, 32'hDEADBEEF);
    xact(1'b0, 1'b0, 2'b10, 16'h0010, 32'h0);
    check("t1_we", 64'(bt_we[0]), 64'(0));
    check("t1_rdata", 64'(rsp_data), 64'(32'hDEADBEEF));

    // 2: byte store in top lane
    xact(1'b0, 1'b1, 2'b00, 16'h0013, 32'h000000AB);
    check("t2_addr", 64'(bt_addr[0]), 64'(4));
    check("t2_we", 64'(bt_we[0]), 64'(4'b1000));
    check("t2_wdata", 64'(bt_wdata[0]), 64'(32'hAB000000));

    // 3: split halfword load
    poke_word(14'd4, 32'h11223344);
    poke_word(14'd5, 32'h55667788);
    xact(1'b0, 1'b0, 2'b01, 16'h0013, 32'h0);
    check("t3_addr1", 64'(bt_addr[1]), 64'(5));
    check("t3_we", 64'({bt_we[0], bt_we[1]}), 64'(0));
    check("t3_rdata", 64'(rsp_data), 64'(32'h00008811));

    // 4: split word store, then read it back
    xact(1'b1, 1'b1, 2'b10, 16'h0006, 32'hA1B2C3D4);
    check("t4_b0", 64'({bt_addr[0], bt_we[0], bt_wdata[0]}), 64'({14'd1, 4'b1100, 32'hC3D40000}));
    check("t4_b1", 64'({bt_addr[1], bt_we[1], bt_wdata[1]}), 64'({14'd2, 4'b0011, 32'h0000A1B2}));
    check("t4_b1_time", 64'(bt_cyc[1]), 64'(1));
    xact(1'b0, 1'b0, 2'b10, 16'h0006, 32'h0);
    check("t4_readback", 64'(rsp_data), 64'(32'hA1B2C3D4));

    // 6a: word load wrapping past the top of memory
    xact(1'b0, 1'b0, 2'b10, 16'hFFFE, 32'h0);
    check("t6_wrap", 64'({bt_addr[0], bt_addr[1]}), 64'({14'h3FFF, 14'h0000}));

    // 6b: reset during ACC1 of a split store
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'b10, 16'h0021, 32'hCAFEF00D);
    #1;
    check("t6_ready", 64'(m1_req_ready), 64'(1));
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    check("t6_in_acc1", 64'({ram_en, ram_addr}), 64'({1'b1, 14'h0009}));
    rst_n = 1'b0;
    #1;
    check("t6_rst_now", 64'({ram_en, ram_we, busy, m1_rsp_valid, rsp_rdata}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_rsp", 64'({m0_rsp_valid, m1_rsp_valid, busy}), 64'(0));
    end
    rst_n = 1'b1;

    // 5: contention straight after reset
    exp0 = ref_load(16'h0010, 2'b10);
    exp1 = ref_load(16'h0040, 2'b10);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 16'h0010, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 16'h0040, 32'h0);
    #1;
    check("t5_m0_ready", 64'(m0_req_ready), 64'(1));
    check("t5_m1_ready", 64'(m1_req_ready), 64'(0));
    @(posedge clk);
    #1;
    n0 = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        check("t5_ready_low", 64'({m0_req_ready, m1_req_ready}), 64'(0));
        check("t5_m1_rsp_quiet", 64'(m1_rsp_valid), 64'(0));
        if (m0_rsp_valid) begin
          n0++;
          check("t5_m0_rdata", 64'(rsp_rdata), 64'(exp0));
        end
      end else done = 1'b1;
    end
    check("t5_m0_rsp_once", 64'(n0), 64'(1));
    check("t5_m1_next", 64'({m1_req_ready, m0_req_ready}), 64'(2'b10));
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0);
    n1 = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      check("t5_m0_rsp_quiet", 64'(m0_rsp_valid), 64'(0));
      if (m1_rsp_valid) begin
        n1++; done = 1'b1;
        check("t5_m1_rdata", 64'(rsp_rdata), 64'(exp1));
      end
    end
    check("t5_m1_rsp_once", 64'(n1), 64'(1));

    // Recover from the abandoned store, then confirm normal operation
    xact(1'b1, 1'b1, 2'b10, 16'h0021, 32'hCAFEF00D);
    xact(1'b0, 1'b0, 2'b10, 16'h0021, 32'h0);
    check("t6_after_rst", 64'(rsp_data), 64'(32'hCAFEF00D));

    // Randomized traffic over a small window plus the top-of-memory wrap
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) ra = 16'hFFF8 + 16'($urandom_range(0, 7));
      else ra = 16'($urandom_range(0, 63));
      xact(1'($urandom), 1'($urandom), 2'($urandom), ra, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
